// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a decoupling prefetch queue.
// Issues word-aligned fetches (one outstanding) over a req/gnt/rvalid handshake
// and buffers up to QDEPTH {pc, instr} entries for decode (valid/ready).
// Execute-stage redirects flush the queue and discard any in-flight response.
// Optional build macro FETCH_PREDECODE_EN folds unconditional B instructions
// in the fetch stage instead of enqueueing them.
module fetch_queue #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter int unsigned        QDEPTH   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_pc,
    input  logic [15:0]        redir_offset
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W-1:0]    head_n;
    logic [PTR_W-1:0]    tail_n;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_n;
    logic                grant;
    logic                pop;
    logic                push;
    logic                fold;
    logic                space_n;
    logic [ADDR_W-1:0]   seq_pc;
    logic [ADDR_W-1:0]   redir_tgt;
    logic [ADDR_W-1:0]   head_pc_n;
    logic [INSTR_W-1:0]  head_data_n;

    logic [ADDR_W-1:0]   pc_mem   [QDEPTH];
    logic [INSTR_W-1:0]  data_mem [QDEPTH];

    // The fetch address register drives the memory port directly.
    assign imem_addr = fetch_pc;

    assign grant     = imem_req && imem_gnt;
    assign pop       = inst_valid && inst_ready;
    assign seq_pc    = fetch_pc + ADDR_W'(4);
    assign redir_tgt = redir_pc + ADDR_W'(4) + (ADDR_W'($signed(redir_offset)) << 2);

`ifdef FETCH_PREDECODE_EN
    logic [ADDR_W-1:0] fold_tgt;

    // Unconditional B: top bits 11 and opcode field 0000; folded, never enqueued.
    assign fold     = (imem_rdata[31:30] == 2'b11) && (imem_rdata[28:25] == 4'b0000);
    assign fold_tgt = seq_pc + (ADDR_W'($signed(imem_rdata[15:0])) << 2);
`else
    assign fold = 1'b0;
`endif

    // A redirect suppresses the response in the same cycle.
    assign push = (state == WAIT) && imem_rvalid && !redir_valid && !fold;

    // Next queue pointers and occupancy; a redirect flushes everything.
    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        if (redir_valid) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
        end else begin
            if (push) begin
                tail_n = tail + PTR_W'(1);
            end
            if (pop) begin
                head_n = head + PTR_W'(1);
            end
            if (push && !pop) begin
                count_n = count + CNT_W'(1);
            end else if (!push && pop) begin
                count_n = count - CNT_W'(1);
            end
        end
    end

    assign space_n = (count_n < CNT_W'(QDEPTH));

    // Next head entry, forwarding the word being written when it lands at the head.
    always_comb begin
        head_pc_n   = pc_mem[head_n];
        head_data_n = data_mem[head_n];
        if (push && (tail == head_n)) begin
            head_pc_n   = fetch_pc;
            head_data_n = imem_rdata;
        end
    end

    // Queue storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= fetch_pc;
            data_mem[tail] <= imem_rdata;
        end
    end

    // Queue pointers, occupancy and registered head outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else begin
            head       <= head_n;
            tail       <= tail_n;
            count      <= count_n;
            inst_valid <= (count_n != '0);
            if (count_n != '0) begin
                inst_pc   <= head_pc_n;
                inst_data <= head_data_n;
            end
        end
    end

    // Fetch FSM: request issue, response wait/discard and redirect handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            imem_req <= 1'b0;
        end else if (redir_valid) begin
            fetch_pc <= redir_tgt;
            case (state)
                IDLE: begin
                    state    <= ISSUE;
                    imem_req <= space_n;
                end
                ISSUE: begin
                    if (grant) begin
                        state    <= DISCARD;
                        imem_req <= 1'b0;
                    end else begin
                        state    <= ISSUE;
                        imem_req <= space_n;
                    end
                end
                WAIT, DISCARD: begin
                    if (imem_rvalid) begin
                        state    <= ISSUE;
                        imem_req <= space_n;
                    end else begin
                        state    <= DISCARD;
                        imem_req <= 1'b0;
                    end
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state    <= ISSUE;
                    imem_req <= space_n;
                end
                ISSUE: begin
                    if (grant) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= space_n;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
`ifdef FETCH_PREDECODE_EN
                        fetch_pc <= fold ? fold_tgt : seq_pc;
`else
                        fetch_pc <= seq_pc;
`endif
                        state    <= ISSUE;
                        imem_req <= space_n;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid) begin
                        state    <= ISSUE;
                        imem_req <= space_n;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue. A memory model answers
// grants after a programmable latency; expected {pc, instr} entries are queued
// at grant time and compared when decode pops them. A second instance with a
// 16-bit address space exercises PC wrap.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [15:0] redir_offset;

    logic        w_req;
    logic [15:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_inst_valid;
    logic        w_inst_ready;
    logic [31:0] w_inst_data;
    logic [15:0] w_inst_pc;
    logic        w_redir_valid;
    logic [15:0] w_redir_pc;
    logic [15:0] w_redir_offset;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W(32), .INSTR_W(32), .QDEPTH(4), .RESET_PC(32'h0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_offset(redir_offset)
    );

    fetch_queue #(
        .ADDR_W(16), .INSTR_W(32), .QDEPTH(4), .RESET_PC(16'hFFFC)
    ) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .redir_valid(w_redir_valid), .redir_pc(w_redir_pc), .redir_offset(w_redir_offset)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic [31:0] rpc;
        logic [15:0] off;
        logic [31:0] exp_addr;
    } redir_vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    sb_t         sb[$];
    logic [31:0] exp_addr;
    bit          pend;
    logic [31:0] pend_data;
    int          pend_cnt;
    int          lat;
    bit          use_b;
    bit          last_grant;
    logic [31:0] last_grant_addr;
    int          w_ngrant;
    logic [15:0] w_addr0;
    logic [15:0] w_addr1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [31:0] memdata(input logic [31:0] a);
        if (use_b && a == 32'h10) return 32'hC000_0003;
        return 32'h5A00_0000 ^ a;
    endfunction

    function automatic bit is_b(input logic [31:0] d);
`ifdef FETCH_PREDECODE_EN
        return (d[31:30] == 2'b11) && (d[28:25] == 4'b0000);
`else
        return (d[31] & ~d[31]);
`endif
    endfunction

    function automatic logic [31:0] calc_tgt(input logic [31:0] pc, input logic [15:0] off);
        return pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
    endfunction

    // One clock cycle: account for this cycle's events, then advance to the next negedge.
    task automatic tick();
        sb_t         e;
        logic [31:0] d;
        bit          grant;
        bit          w_grant;
        grant      = imem_req && imem_gnt;
        last_grant = grant;
        if (inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got pc 0x%0h expected no entry", inst_pc);
            end else begin
                e = sb.pop_front();
                check("pop_pc", {32'h0, inst_pc}, {32'h0, e.pc});
                check("pop_data", {32'h0, inst_data}, {32'h0, e.data});
            end
        end
        if (grant) begin
            check("grant_addr", {32'h0, imem_addr}, {32'h0, exp_addr});
            last_grant_addr = imem_addr;
            d         = memdata(imem_addr);
            pend      = 1'b1;
            pend_data = d;
            pend_cnt  = lat;
        end else begin
            d = '0;
        end
        if (redir_valid) begin
            sb.delete();
            exp_addr = calc_tgt(redir_pc, redir_offset);
        end else if (grant) begin
            if (is_b(d)) begin
                exp_addr = calc_tgt(imem_addr, d[15:0]);
            end else begin
                e.pc   = imem_addr;
                e.data = d;
                sb.push_back(e);
                exp_addr = imem_addr + 32'd4;
            end
        end
        w_grant = w_req && w_gnt;
        if (w_grant) begin
            if (w_ngrant == 0) w_addr0 = w_addr;
            else if (w_ngrant == 1) w_addr1 = w_addr;
            w_ngrant++;
        end
        @(posedge clk);
        @(negedge clk);
        redir_valid = 1'b0;
        imem_rvalid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
                pend        = 1'b0;
            end
        end
        w_rvalid = w_grant;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        imem_rvalid = 1'b0;
        w_rvalid    = 1'b0;
        pend        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", {63'h0, imem_req}, 64'h0);
        check("rst_addr", {32'h0, imem_addr}, 64'h0);
        check("rst_valid", {63'h0, inst_valid}, 64'h0);
        check("rst_data", {32'h0, inst_data}, 64'h0);
        check("rst_pc", {32'h0, inst_pc}, 64'h0);
        check("rst_wrap_addr", {48'h0, w_addr}, 64'hFFFC);
        sb.delete();
        exp_addr = 32'h0;
        w_ngrant = 0;
        rst      = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!last_grant && k < 100);
        if (!last_grant) fail_now(name);
    endtask

    task automatic drain();
        int k;
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        k = 0;
        while ((sb.size() != 0 || pend || imem_rvalid || inst_valid) && k < 100) begin
            tick();
            k++;
        end
        check("drain_sb_empty", 64'(sb.size()), 64'h0);
        check("drain_valid", {63'h0, inst_valid}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1);
    end

    initial begin
        redir_vec_t vecs[6];
        int first_req;
        int first_val;
        int pops;
        int grants;
        int k;

        vecs[0] = '{rpc: 32'h0000_0020, off: 16'hFFFE, exp_addr: 32'h0000_001C};
        vecs[1] = '{rpc: 32'h0000_0100, off: 16'h0000, exp_addr: 32'h0000_0104};
        vecs[2] = '{rpc: 32'h0000_0000, off: 16'h0001, exp_addr: 32'h0000_0008};
        vecs[3] = '{rpc: 32'hFFFF_FFFC, off: 16'h0000, exp_addr: 32'h0000_0000};
        vecs[4] = '{rpc: 32'h0000_0040, off: 16'h7FFF, exp_addr: 32'h0002_0040};
        vecs[5] = '{rpc: 32'h0000_1000, off: 16'h8000, exp_addr: 32'hFFFE_1004};

        imem_rdata     = '0;
        redir_pc       = '0;
        redir_offset   = '0;
        use_b          = 1'b0;
        lat            = 1;
        w_gnt          = 1'b1;
        w_rdata        = 32'h1234_5678;
        w_inst_ready   = 1'b1;
        w_redir_valid  = 1'b0;
        w_redir_pc     = '0;
        w_redir_offset = '0;
        last_grant_addr = '0;

        // Streaming fetch with 1-cycle memory and decode always ready.
        do_reset();
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        first_req  = 0;
        first_val  = 0;
        pops       = 0;
        for (int c = 1; c <= 20; c++) begin
            if (imem_req && first_req == 0) first_req = c;
            if (inst_valid && first_val == 0) first_val = c;
            if (inst_valid && inst_ready) pops++;
            tick();
        end
        check("first_req_cycle", 64'(first_req), 64'd2);
        check("first_valid_cycle", 64'(first_val), 64'd4);
        check("pops_in_20", 64'(pops), 64'd9);
        check("wrap_first_addr", {48'h0, w_addr0}, 64'hFFFC);
        check("wrap_second_addr", {48'h0, w_addr1}, 64'h0000);
        drain();

        // Back-pressure: queue fills, requests stop, one pop frees one slot.
        do_reset();
        imem_gnt   = 1'b1;
        inst_ready = 1'b0;
        grants     = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (last_grant) grants++;
        end
        check("full_grants", 64'(grants), 64'd4);
        check("full_req_low", {63'h0, imem_req}, 64'h0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (last_grant) grants++;
        end
        check("one_pop_one_grant", 64'(grants), 64'd1);

        // Redirect while waiting on a slow response; the late response is dropped.
        lat        = 3;
        inst_ready = 1'b1;
        wait_grant("t3_grant");
        inst_ready   = 1'b0;
        redir_valid  = 1'b1;
        redir_pc     = 32'h20;
        redir_offset = 16'hFFFE;
        tick();
        check("wait_redir_valid", {63'h0, inst_valid}, 64'h0);
        check("wait_redir_addr", {32'h0, imem_addr}, 64'h1C);
        check("wait_redir_req", {63'h0, imem_req}, 64'h0);
        inst_ready = 1'b1;
        wait_grant("t3_regrant");
        check("wait_redir_next_grant", {32'h0, last_grant_addr}, 64'h1C);
        drain();
        lat = 1;

        // Redirect coinciding with a response and a queue pop.
        imem_gnt   = 1'b1;
        inst_ready = 1'b0;
        k = 0;
        while (!(imem_rvalid && inst_valid) && k < 50) begin
            tick();
            k++;
        end
        if (!(imem_rvalid && inst_valid)) fail_now("t4_setup");
        inst_ready   = 1'b1;
        redir_valid  = 1'b1;
        redir_pc     = 32'h200;
        redir_offset = 16'h0003;
        tick();
        inst_ready = 1'b0;
        check("rv_redir_valid", {63'h0, inst_valid}, 64'h0);
        check("rv_redir_req", {63'h0, imem_req}, 64'h1);
        check("rv_redir_addr", {32'h0, imem_addr}, 64'h210);

        // Table of redirect targets applied from varied pipeline states.
        for (int i = 0; i < 6; i++) begin
            imem_gnt   = 1'b1;
            inst_ready = (i % 2 == 1);
            lat        = 1 + (i % 3);
            repeat (3 + i) tick();
            redir_valid  = 1'b1;
            redir_pc     = vecs[i].rpc;
            redir_offset = vecs[i].off;
            tick();
            check($sformatf("vec%0d_addr", i), {32'h0, imem_addr}, {32'h0, vecs[i].exp_addr});
            check($sformatf("vec%0d_valid", i), {63'h0, inst_valid}, 64'h0);
        end
        drain();
        lat = 1;

        // Unconditional B at PC 0x10: folded with predecode, enqueued without.
        use_b        = 1'b1;
        imem_gnt     = 1'b0;
        inst_ready   = 1'b1;
        redir_valid  = 1'b1;
        redir_pc     = 32'h0C;
        redir_offset = 16'h0000;
        tick();
        imem_gnt = 1'b1;
        wait_grant("b_grant");
        check("b_fetch_addr", {32'h0, last_grant_addr}, 64'h10);
        wait_grant("b_next_grant");
`ifdef FETCH_PREDECODE_EN
        check("b_next_addr", {32'h0, last_grant_addr}, 64'h20);
`else
        check("b_next_addr", {32'h0, last_grant_addr}, 64'h14);
`endif
        drain();
        use_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
